exec_multicycle: RTL and testbench
==================================

EXEC_MULTICYCLE -- requirements
Module: exec_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_FWD, default 2, number of forwarding sources (index 0 = nearest stage, i.e. memory).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port valid_e  input  1  an instruction is present in execute.
REQ-006 SHALL have port flush_e  input  1  discards the execute instruction, aborting any in-flight operation.
REQ-007 SHALL have port op_e  input  alu_op_e  operation (ALU, MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU).
REQ-008 SHALL have ports rd1_e, rd2_e, imm_ext_e, pc_e  input  XLEN  register operands, immediate, PC.
REQ-009 SHALL have port alu_src_e  input  1  selects imm_ext_e as operand B.
REQ-010 SHALL have ports branch_e, jump_e, jalr_e  input  1 each; funct3_e  input  3  branch condition.
REQ-011 SHALL have port fwd_data  input  NUM_FWD x XLEN  forwarded results.
REQ-012 SHALL have ports forward_a_e, forward_b_e  input  $clog2(NUM_FWD+1)  operand source selects.
REQ-013 SHALL have ports alu_result_e, write_data_e, pc_target_e  output  XLEN.
REQ-014 SHALL have ports pc_src_e, stall_e, result_valid_e  output  1.

Function
REQ-015 Select 0 SHALL pick rd1_e/rd2_e; select k (1..NUM_FWD) SHALL pick fwd_data[k-1]; select > NUM_FWD SHALL drive 'x.
REQ-016 write_data_e SHALL be the forwarded operand B before the alu_src_e mux.
REQ-017 ALU ops SHALL complete combinationally: stall_e=0, result_valid_e=valid_e same cycle.
REQ-018 Multi-cycle ops (DIV/DIVU/REM/REMU; MUL* unless REQ-031 applies) SHALL use FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-019 IDLE with valid_e & multi-cycle op & !flush_e: latch operands, load counter=XLEN, go BUSY; stall_e=1 this cycle.
REQ-020 BUSY: one result bit per cycle, counter decrements; stall_e=1; at counter==1 go DONE.
REQ-021 DONE: alu_result_e = registered result, stall_e=0, result_valid_e=1, go IDLE next edge without re-issuing the held instruction.
REQ-022 Total stall SHALL be exactly XLEN+1 cycles; result on cycle XLEN+1 after issue.
REQ-023 Divide by zero: quotient = all ones, remainder = dividend; signed MIN/-1: quotient = MIN, remainder = 0; latency unchanged.
REQ-024 flush_e in any state SHALL force IDLE next edge; stall_e and result_valid_e SHALL be 0 in the flush cycle.
REQ-025 pc_target_e SHALL be pc_e+imm_ext_e, or (opA+imm_ext_e) with bit 0 cleared when jalr_e.
REQ-026 pc_src_e = valid_e & !flush_e & (jump_e | branch_e & cond), cond per funct3 BEQ/BNE/BLT/BGE/BLTU/BGEU, reserved funct3 SHALL yield 0; pc_src_e SHALL be 0 while stall_e.
REQ-027 Result/pc arithmetic SHALL wrap modulo 2^XLEN.

Reset
REQ-028 rst SHALL force IDLE, counter=0, result register=0 immediately.
REQ-029 During and after rst: stall_e=0, result_valid_e=0, pc_src_e=0; rst mid-BUSY SHALL discard the operation.
REQ-030 Combinational outputs SHALL follow inputs once rst deasserts.

Configuration
REQ-031 With FAST_MUL_EN defined, MUL* SHALL complete single-cycle per REQ-017 (full 2*XLEN product, high/low selected); without it MUL* SHALL use the iterative shift-add path per REQ-018..022.

Structure
REQ-032 Package exec_pkg SHALL hold alu_op_e, funct3 branch constants, and the FSM state enum.
REQ-033 Iterative multiply/divide datapath SHALL be sub-module muldiv_iter (operands, op, start, flush -> result, done).

Verification
REQ-034 ADD rd1=5, rd2=7, fwd_b=0 -> alu_result_e=12, stall_e=0, result_valid_e=1 same cycle.
REQ-035 forward_a_e=2, fwd_data[1]=0x100, SUB imm 0x10 -> 0xF0.
REQ-036 DIVU 100/7 -> stall_e high 33 cycles, then result_valid_e=1, alu_result_e=14; REMU -> 2.
REQ-037 DIV 0x80000000/-1 -> 0x80000000; DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
REQ-038 flush_e at BUSY cycle 10 -> IDLE next edge, stall_e=0; rst mid-BUSY -> same, no result_valid_e.
REQ-039 BLT with -1 vs 1 -> pc_src_e=1, pc_target_e=pc_e+imm; JALR opA=0x1001, imm=4 -> 0x1004.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, branch funct3 codes and
// the multiply/divide sequencer state.
package exec_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_PASSB,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } md_state_e;

    function automatic logic is_mul(input alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/exec_multicycle_if.sv
// Decode-to-execute bus: operands, control and forwarding inputs, plus the
// execute results and stall/branch outputs.
interface exec_multicycle_if import exec_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
);
    localparam int SEL_W = $clog2(NUM_FWD + 1);

    logic                            valid_e;
    logic                            flush_e;
    alu_op_e                         op_e;
    logic [XLEN-1:0]                 rd1_e;
    logic [XLEN-1:0]                 rd2_e;
    logic [XLEN-1:0]                 imm_ext_e;
    logic [XLEN-1:0]                 pc_e;
    logic                            alu_src_e;
    logic                            branch_e;
    logic                            jump_e;
    logic                            jalr_e;
    logic [2:0]                      funct3_e;
    logic [NUM_FWD-1:0][XLEN-1:0]    fwd_data;
    logic [SEL_W-1:0]                forward_a_e;
    logic [SEL_W-1:0]                forward_b_e;
    logic [XLEN-1:0]                 alu_result_e;
    logic [XLEN-1:0]                 write_data_e;
    logic [XLEN-1:0]                 pc_target_e;
    logic                            pc_src_e;
    logic                            stall_e;
    logic                            result_valid_e;

    modport master (
        output valid_e, flush_e, op_e, rd1_e, rd2_e, imm_ext_e, pc_e,
               alu_src_e, branch_e, jump_e, jalr_e, funct3_e,
               fwd_data, forward_a_e, forward_b_e,
        input  alu_result_e, write_data_e, pc_target_e,
               pc_src_e, stall_e, result_valid_e
    );

    modport slave (
        input  valid_e, flush_e, op_e, rd1_e, rd2_e, imm_ext_e, pc_e,
               alu_src_e, branch_e, jump_e, jalr_e, funct3_e,
               fwd_data, forward_a_e, forward_b_e,
        output alu_result_e, write_data_e, pc_target_e,
               pc_src_e, stall_e, result_valid_e
    );

endinterface

// File: rtl/exec_multicycle_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one result bit per
// cycle, sequenced IDLE -> BUSY (XLEN cycles) -> DONE.
module muldiv_iter import exec_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(XLEN + 1);

    md_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    alu_op_e         op_q;
    logic            mul_q, neg_p_q, neg_r_q, div_zero_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q, result_q;

    logic            sgn_a, sgn_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] hi_n, lo_n, final_res;
    logic [2*XLEN-1:0] prod;

    // Signed ops run on magnitudes; the sign is re-applied once at the end.
    always_comb begin
        sgn_a = a[XLEN-1] && (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sgn_b = b[XLEN-1] && (op inside {OP_MULH, OP_DIV, OP_REM});
        mag_a = sgn_a ? -a : a;
        mag_b = sgn_b ? -b : b;
    end

    // NOTE: every always_comb output gets a value on every path (here via the
    // if/else pair); a missing branch would silently infer a latch.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        if (mul_q) begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            hi_n = div_ge ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], div_ge};
        end
    end

    always_comb begin
        prod = {hi_n, lo_n};
        if (neg_p_q) prod = -prod;
        case (op_q)
            OP_MUL:                       final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = div_zero_q ? '1 : (neg_p_q ? -lo_n : lo_n);
            default:                      final_res = neg_r_q ? -hi_n : hi_n;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            op_q       <= OP_ADD;
            mul_q      <= 1'b0;
            neg_p_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        mul_q      <= is_mul(op);
                        neg_p_q    <= sgn_a ^ sgn_b;
                        neg_r_q    <= sgn_a;
                        div_zero_q <= (b == '0);
                        hi_q       <= '0;
                        lo_q       <= is_mul(op) ? mag_b : mag_a;
                        opnd_q     <= is_mul(op) ? mag_a : mag_b;
                        cnt_q      <= CW'(XLEN);
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= final_res;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign busy   = (state_q == ST_BUSY);
    assign done   = (state_q == ST_DONE);

endmodule

// File: rtl/exec_multicycle.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch/jump resolution
// and a stalling multi-cycle MUL/DIV unit. FAST_MUL_EN makes MUL* single-cycle.
module exec_multicycle import exec_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input logic              clk,
    input logic              rst,
    exec_multicycle_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_FWD + 1);
    localparam int SH_W  = $clog2(XLEN);

    logic [XLEN-1:0] src_a, src_b_fwd, src_b, alu_out, md_result;
    logic            is_multi, start, md_busy, md_done, cond, stall;

    // Selects above NUM_FWD are undefined and left as don't-care.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [SEL_W-1:0]              sel,
        input logic [XLEN-1:0]               reg_val,
        input logic [NUM_FWD-1:0][XLEN-1:0]  fwd
    );
        logic [XLEN-1:0] v;
        v = 'x;
        if (sel == '0) v = reg_val;
        for (int k = 1; k <= NUM_FWD; k++)
            if (int'(sel) == k) v = fwd[k-1];
        return v;
    endfunction

    always_comb begin
        src_a     = fwd_sel(bus.forward_a_e, bus.rd1_e, bus.fwd_data);
        src_b_fwd = fwd_sel(bus.forward_b_e, bus.rd2_e, bus.fwd_data);
        src_b     = bus.alu_src_e ? bus.imm_ext_e : src_b_fwd;
    end

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    always_comb begin
        ext_a = (bus.op_e inside {OP_MULH, OP_MULHSU}) ? {{XLEN{src_a[XLEN-1]}}, src_a}
                                                       : {{XLEN{1'b0}}, src_a};
        ext_b = (bus.op_e == OP_MULH) ? {{XLEN{src_b[XLEN-1]}}, src_b}
                                      : {{XLEN{1'b0}}, src_b};
        fast_prod = ext_a * ext_b;
    end
    assign is_multi = is_div(bus.op_e);
`else
    assign is_multi = is_div(bus.op_e) || is_mul(bus.op_e);
`endif

    always_comb begin
        case (bus.op_e)
            OP_ADD:   alu_out = src_a + src_b;
            OP_SUB:   alu_out = src_a - src_b;
            OP_AND:   alu_out = src_a & src_b;
            OP_OR:    alu_out = src_a | src_b;
            OP_XOR:   alu_out = src_a ^ src_b;
            OP_SLL:   alu_out = src_a << src_b[SH_W-1:0];
            OP_SRL:   alu_out = src_a >> src_b[SH_W-1:0];
            OP_SRA:   alu_out = $signed(src_a) >>> src_b[SH_W-1:0];
            OP_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU:  alu_out = {{(XLEN-1){1'b0}}, src_a < src_b};
            OP_PASSB: alu_out = src_b;
`ifdef FAST_MUL_EN
            OP_MUL:                       alu_out = fast_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_out = fast_prod[2*XLEN-1:XLEN];
`endif
            default:  alu_out = '0;
        endcase
    end

    always_comb begin
        case (bus.funct3_e)
            F3_BEQ:  cond = (src_a == src_b_fwd);
            F3_BNE:  cond = (src_a != src_b_fwd);
            F3_BLT:  cond = ($signed(src_a) <  $signed(src_b_fwd));
            F3_BGE:  cond = ($signed(src_a) >= $signed(src_b_fwd));
            F3_BLTU: cond = (src_a <  src_b_fwd);
            F3_BGEU: cond = (src_a >= src_b_fwd);
            default: cond = 1'b0;
        endcase
    end

    assign start = bus.valid_e && is_multi && !bus.flush_e;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (bus.flush_e),
        .op     (bus.op_e),
        .a      (src_a),
        .b      (src_b),
        .result (md_result),
        .busy   (md_busy),
        .done   (md_done)
    );

    // The issue cycle stalls too, which is what makes the total XLEN+1.
    assign stall = !rst && !bus.flush_e && (md_busy || (start && !md_done));

    assign bus.stall_e        = stall;
    assign bus.result_valid_e = !rst && !bus.flush_e &&
                                (md_done || (bus.valid_e && !is_multi));
    assign bus.alu_result_e   = md_done ? md_result : alu_out;
    assign bus.write_data_e   = src_b_fwd;
    assign bus.pc_target_e    = bus.jalr_e ? ((src_a + bus.imm_ext_e) & ~XLEN'(1))
                                           : (bus.pc_e + bus.imm_ext_e);
    assign bus.pc_src_e       = !rst && bus.valid_e && !bus.flush_e && !stall &&
                                (bus.jump_e || (bus.branch_e && cond));

endmodule

// File: tb/tb_exec_multicycle.sv
// Directed bench for exec_multicycle: ALU/branch vector table, then
// multiply/divide latency, flush and reset-abort sequences.
module tb_exec_multicycle;
    import exec_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    exec_multicycle_if #(.XLEN(32), .NUM_FWD(2)) ifc ();

    exec_multicycle #(.XLEN(32), .NUM_FWD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        alu_op_e     op;
        logic [31:0] a, b, imm, pc;
        logic        alu_src;
        logic [1:0]  fa, fb;
        logic        br, jmp, jalr;
        logic [2:0]  f3;
        logic [31:0] e_res, e_wd;
        logic        e_src;
        logic [31:0] e_tgt;
    } vec_t;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a, b, exp;
    } mvec_t;

    localparam int NV = 19;
    localparam int NM = 16;
    vec_t  vecs [NV];
    mvec_t mvecs[NM];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ifc.valid_e     = 1'b0;
        ifc.flush_e     = 1'b0;
        ifc.op_e        = OP_ADD;
        ifc.rd1_e       = '0;
        ifc.rd2_e       = '0;
        ifc.imm_ext_e   = '0;
        ifc.pc_e        = 32'h1000;
        ifc.alu_src_e   = 1'b0;
        ifc.branch_e    = 1'b0;
        ifc.jump_e      = 1'b0;
        ifc.jalr_e      = 1'b0;
        ifc.funct3_e    = 3'd0;
        ifc.forward_a_e = 2'd0;
        ifc.forward_b_e = 2'd0;
    endtask

    task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        idle_inputs();
        ifc.valid_e = 1'b1;
        ifc.op_e    = op;
        ifc.rd1_e   = a;
        ifc.rd2_e   = b;
    endtask

    function automatic int exp_lat(input alu_op_e op);
`ifdef FAST_MUL_EN
        if (is_mul(op)) return 0;
`endif
        return 33;
    endfunction

    task automatic run_multi(input string name, input alu_op_e op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        int stalls = 0;
        @(negedge clk);
        issue(op, a, b);
        #1;
        while (ifc.stall_e === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check({name, " stall cycles"}, 32'(stalls), 32'(exp_lat(op)));
        check({name, " result_valid"}, 32'(ifc.result_valid_e), 32'd1);
        check({name, " result"}, ifc.alu_result_e, exp);
        @(negedge clk);
        idle_inputs();
        #1;
        check({name, " back to idle"}, 32'({ifc.stall_e, ifc.result_valid_e}), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, OP_ADD,  32'd5,        32'd7,        32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd12,       32'd7,        1'b0, 32'h1000};
        vecs[1]  = '{1'b1, OP_SUB,  32'h55,       32'h33,       32'h10,       32'h1000, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hF0,       32'h33,       1'b0, 32'h1010};
        vecs[2]  = '{1'b1, OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h00F000F0, 32'h0FF00FF0, 1'b0, 32'h1000};
        vecs[3]  = '{1'b1, OP_SRA,  32'h80000000, 32'd4,        32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hF8000000, 32'd4,        1'b0, 32'h1000};
        vecs[4]  = '{1'b1, OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1,        32'd1,        1'b0, 32'h1000};
        vecs[5]  = '{1'b1, OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0,        32'd1,        1'b0, 32'h1000};
        vecs[6]  = '{1'b1, OP_ADD,  32'hFFFFFFFF, 32'd2,        32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1,        32'd2,        1'b0, 32'h1000};
        vecs[7]  = '{1'b1, OP_SUB,  32'hFFFFFFFF, 32'd1,        32'h40,       32'h2000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4, 32'hFFFFFFFE, 32'd1,        1'b1, 32'h2040};
        vecs[8]  = '{1'b1, OP_ADD,  32'hFFFFFFFF, 32'd1,        32'h40,       32'h2000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd6, 32'd0,        32'd1,        1'b0, 32'h2040};
        vecs[9]  = '{1'b1, OP_XOR,  32'h1234,     32'h1234,     32'd8,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd2, 32'd0,        32'h1234,     1'b0, 32'h1008};
        vecs[10] = '{1'b1, OP_ADD,  32'h1001,     32'd0,        32'd4,        32'h1000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0, 32'h1005,     32'd0,        1'b1, 32'h1004};
        vecs[11] = '{1'b1, OP_OR,   32'h5555,     32'h77,       32'd0,        32'h1000, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hAAAA5555, 32'hAAAA0000, 1'b0, 32'h1000};
        vecs[12] = '{1'b1, OP_SUB,  32'h100,      32'd0,        32'hFFFFFFF0, 32'h3000, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0,        32'h100,      1'b1, 32'h2FF0};
        vecs[13] = '{1'b0, OP_ADD,  32'd1,        32'd1,        32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd2,        32'd1,        1'b0, 32'h1000};
        vecs[14] = '{1'b1, OP_SLL,  32'd1,        32'h21,       32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd2,        32'h21,       1'b0, 32'h1000};
        vecs[15] = '{1'b1, OP_SRL,  32'h80000000, 32'd31,       32'd0,        32'h1000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1,        32'd31,       1'b0, 32'h1000};
        vecs[16] = '{1'b1, OP_PASSB,32'd0,        32'd5,        32'hDEADBEEF, 32'h1000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'hDEADBEEF, 32'd5,        1'b0, 32'hDEADCEEF};
        vecs[17] = '{1'b1, OP_ADD,  32'hFFFFFFFF, 32'd1,        32'h40,       32'h2000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd5, 32'd0,        32'd1,        1'b0, 32'h2040};
        vecs[18] = '{1'b1, OP_XOR,  32'd0,        32'hAAAA0000, 32'd0,        32'h1000, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd1, 32'd0,        32'hAAAA0000, 1'b0, 32'h1000};

        mvecs[0]  = '{OP_DIVU,   32'd100,        32'd7,          32'd14};
        mvecs[1]  = '{OP_REMU,   32'd100,        32'd7,          32'd2};
        mvecs[2]  = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000};
        mvecs[3]  = '{OP_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0};
        mvecs[4]  = '{OP_DIV,    32'd5,          32'd0,          32'hFFFFFFFF};
        mvecs[5]  = '{OP_REM,    32'd5,          32'd0,          32'd5};
        mvecs[6]  = '{OP_DIVU,   32'd5,          32'd0,          32'hFFFFFFFF};
        mvecs[7]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
        mvecs[8]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
        mvecs[9]  = '{OP_MUL,    32'hFFFFFFFF,   32'd3,          32'hFFFFFFFD};
        mvecs[10] = '{OP_MULHU,  32'hFFFFFFFF,   32'd3,          32'd2};
        mvecs[11] = '{OP_MULH,   32'hFFFFFFFF,   32'd3,          32'hFFFFFFFF};
        mvecs[12] = '{OP_MULHSU, 32'hFFFFFFFF,   32'd3,          32'hFFFFFFFF};
        mvecs[13] = '{OP_MULHSU, 32'd2,          32'hFFFFFFFF,   32'd1};
        mvecs[14] = '{OP_MULH,   32'h80000000,   32'h80000000,   32'h40000000};
        mvecs[15] = '{OP_MUL,    32'd1234,       32'd5678,       32'd7006652};

        ifc.fwd_data[0] = 32'hAAAA0000;
        ifc.fwd_data[1] = 32'h00000100;
        idle_inputs();
        rst = 1'b1;

        // Reset holds outputs quiet even with a multi-cycle op and a jump presented.
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        ifc.jump_e = 1'b1;
        #1;
        check("reset stall_e", 32'(ifc.stall_e), 32'd0);
        check("reset result_valid_e", 32'(ifc.result_valid_e), 32'd0);
        check("reset pc_src_e", 32'(ifc.pc_src_e), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            idle_inputs();
            ifc.valid_e     = vecs[i].valid;
            ifc.op_e        = vecs[i].op;
            ifc.rd1_e       = vecs[i].a;
            ifc.rd2_e       = vecs[i].b;
            ifc.imm_ext_e   = vecs[i].imm;
            ifc.pc_e        = vecs[i].pc;
            ifc.alu_src_e   = vecs[i].alu_src;
            ifc.forward_a_e = vecs[i].fa;
            ifc.forward_b_e = vecs[i].fb;
            ifc.branch_e    = vecs[i].br;
            ifc.jump_e      = vecs[i].jmp;
            ifc.jalr_e      = vecs[i].jalr;
            ifc.funct3_e    = vecs[i].f3;
            #1;
            check($sformatf("v%0d alu_result_e", i), ifc.alu_result_e, vecs[i].e_res);
            check($sformatf("v%0d write_data_e", i), ifc.write_data_e, vecs[i].e_wd);
            check($sformatf("v%0d pc_target_e", i), ifc.pc_target_e, vecs[i].e_tgt);
            check($sformatf("v%0d pc_src_e", i), 32'(ifc.pc_src_e), 32'(vecs[i].e_src));
            check($sformatf("v%0d stall_e", i), 32'(ifc.stall_e), 32'd0);
            check($sformatf("v%0d result_valid_e", i), 32'(ifc.result_valid_e), 32'(vecs[i].valid));
        end

        for (int i = 0; i < NM; i++)
            run_multi($sformatf("m%0d", i), mvecs[i].op, mvecs[i].a, mvecs[i].b, mvecs[i].exp);

        // Flush in the 10th BUSY cycle must abort and return to IDLE.
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        ifc.jump_e = 1'b1;
        #1;
        check("flush issue stall_e", 32'(ifc.stall_e), 32'd1);
        check("flush issue pc_src_e", 32'(ifc.pc_src_e), 32'd0);
        for (int c = 0; c < 10; c++) @(negedge clk);
        ifc.flush_e = 1'b1;
        #1;
        check("flush cycle stall_e", 32'(ifc.stall_e), 32'd0);
        check("flush cycle result_valid_e", 32'(ifc.result_valid_e), 32'd0);
        check("flush cycle pc_src_e", 32'(ifc.pc_src_e), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("after flush stall_e", 32'(ifc.stall_e), 32'd0);
        check("after flush result_valid_e", 32'(ifc.result_valid_e), 32'd0);
        run_multi("post-flush divu", OP_DIVU, 32'd100, 32'd7, 32'd14);

        // Reset mid-BUSY must discard the operation without a late result.
        @(negedge clk);
        issue(OP_DIV, 32'd1000, 32'd3);
        for (int c = 0; c < 6; c++) @(negedge clk);
        ifc.jump_e = 1'b1;
        rst = 1'b1;
        #1;
        check("mid-busy rst stall_e", 32'(ifc.stall_e), 32'd0);
        check("mid-busy rst result_valid_e", 32'(ifc.result_valid_e), 32'd0);
        check("mid-busy rst pc_src_e", 32'(ifc.pc_src_e), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        begin
            int bad = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                #1;
                if (ifc.stall_e !== 1'b0 || ifc.result_valid_e !== 1'b0) bad++;
            end
            check("after rst no stall or result", 32'(bad), 32'd0);
        end
        @(negedge clk);
        issue(OP_ADD, 32'd20, 32'd22);
        #1;
        check("after rst alu_result_e", ifc.alu_result_e, 32'd42);
        check("after rst result_valid_e", 32'(ifc.result_valid_e), 32'd1);
        run_multi("post-rst divu", OP_DIVU, 32'd100, 32'd7, 32'd14);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
